// File: rtl/pcs_tx_code_group_if.sv
// Code-group constants, the ordered-set type, and the bundle between the
// ordered-set stage and the code-group generator.
package pcs_pkg;
  typedef enum logic [2:0] {
    OS_C, OS_I, OS_S, OS_T, OS_R, OS_V, OS_D, OS_LI
  } ordered_set_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] D6_5  = 8'hA6;
  localparam logic [7:0] D26_4 = 8'h9A;
endpackage

interface pcs_tx_code_group_if;
  import pcs_pkg::*;
  ordered_set_t tx_o_set;
  logic         TX_EN;
  logic         TX_ER;
  logic [7:0]   TXD;
  logic [15:0]  tx_config_reg;
  logic         tx_disparity_pos;
  logic [7:0]   tx_code_group;
  logic         tx_is_k;
  logic         tx_even;
  logic         tx_oset_indicate;

  modport master (
    output tx_o_set, TX_EN, TX_ER, TXD, tx_config_reg, tx_disparity_pos,
    input  tx_code_group, tx_is_k, tx_even, tx_oset_indicate
  );
  modport slave (
    input  tx_o_set, TX_EN, TX_ER, TXD, tx_config_reg, tx_disparity_pos,
    output tx_code_group, tx_is_k, tx_even, tx_oset_indicate
  );
endinterface

// File: rtl/pcs_tx_code_group.sv
// PCS transmit code-group generator: ordered sets to one octet + K flag per clock.
// Define PCS_TX_LPI_EN to emit /LI1/ /LI2/ for OS_LI; otherwise OS_LI is sent as /I/.
//
// state  | meaning
// GEN_CG | set boundary, samples tx_o_set and launches its first group
// IDLE_B | second group of /I/ (D5.6 or D16.2)
// LPI_B  | second group of /LI/ (D6.5 or D26.4), LPI build only
// CFG_B  | second group of /C/ (D21.5 for C1, D2.2 for C2)
// CFG_C  | config word low octet
// CFG_D  | config word high octet, last group of /C/
module pcs_tx_code_group
  import pcs_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic power_on,
  input  logic mr_main_reset,
  pcs_tx_code_group_if.slave cg
);

  typedef enum logic [2:0] {
    GEN_CG, IDLE_B, CFG_B, CFG_C, CFG_D
`ifdef PCS_TX_LPI_EN
    , LPI_B
`endif
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  code_q, code_nxt;
  logic        k_q, k_nxt;
  logic        even_q, even_nxt;
  logic        ind_q, ind_nxt;
  logic        c2_q, c2_nxt;
  logic [15:0] cfg_q, cfg_nxt;
  logic        void_d, void_tr;

  assign cg.tx_code_group    = code_q;
  assign cg.tx_is_k          = k_q;
  assign cg.tx_even          = even_q;
  assign cg.tx_oset_indicate = ind_q;

  assign void_d  = cg.TX_EN & cg.TX_ER;
  assign void_tr = cg.TX_EN | (cg.TX_ER & (cg.TXD != 8'h0F));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= GEN_CG;
      code_q <= 8'h00;
      k_q    <= 1'b0;
      even_q <= 1'b0;
      ind_q  <= 1'b0;
      c2_q   <= 1'b0;
      cfg_q  <= 16'h0000;
    end else if (power_on || mr_main_reset) begin
      state  <= GEN_CG;
      code_q <= 8'h00;
      k_q    <= 1'b0;
      even_q <= 1'b0;
      ind_q  <= 1'b0;
      c2_q   <= 1'b0;
      cfg_q  <= 16'h0000;
    end else begin
      state  <= state_nxt;
      code_q <= code_nxt;
      k_q    <= k_nxt;
      even_q <= even_nxt;
      ind_q  <= ind_nxt;
      c2_q   <= c2_nxt;
      cfg_q  <= cfg_nxt;
    end
  end

  always_comb begin
    state_nxt = GEN_CG;
    case (state)
      GEN_CG: begin
        case (cg.tx_o_set)
          OS_C:                         state_nxt = CFG_B;
          OS_S, OS_T, OS_R, OS_V, OS_D: state_nxt = GEN_CG;
`ifdef PCS_TX_LPI_EN
          OS_LI:                        state_nxt = LPI_B;
`endif
          default:                      state_nxt = IDLE_B;
        endcase
      end
      CFG_B:   state_nxt = CFG_C;
      CFG_C:   state_nxt = CFG_D;
      default: state_nxt = GEN_CG;
    endcase
  end

  always_comb begin
    code_nxt = 8'h00;
    k_nxt    = 1'b0;
    even_nxt = 1'b0;
    ind_nxt  = 1'b0;
    c2_nxt   = c2_q;
    cfg_nxt  = cfg_q;
    case (state)
      GEN_CG: begin
        // Single-group sets keep alternating parity; two/four-group sets realign to even.
        case (cg.tx_o_set)
          OS_C: begin
            code_nxt = K28_5;
            k_nxt    = 1'b1;
            even_nxt = 1'b1;
          end
          OS_S, OS_T, OS_R, OS_V, OS_D: begin
            c2_nxt   = 1'b0;
            ind_nxt  = 1'b1;
            even_nxt = ~even_q;
            k_nxt    = 1'b1;
            case (cg.tx_o_set)
              OS_S:    code_nxt = K27_7;
              OS_T:    code_nxt = void_tr ? K30_7 : K29_7;
              OS_R:    code_nxt = void_tr ? K30_7 : K23_7;
              OS_D: begin
                code_nxt = void_d ? K30_7 : cg.TXD;
                k_nxt    = void_d;
              end
              default: code_nxt = K30_7;
            endcase
          end
          default: begin
            c2_nxt   = 1'b0;
            code_nxt = K28_5;
            k_nxt    = 1'b1;
            even_nxt = 1'b1;
          end
        endcase
      end
      IDLE_B: begin
        code_nxt = cg.tx_disparity_pos ? D5_6 : D16_2;
        ind_nxt  = 1'b1;
      end
`ifdef PCS_TX_LPI_EN
      LPI_B: begin
        code_nxt = cg.tx_disparity_pos ? D6_5 : D26_4;
        ind_nxt  = 1'b1;
      end
`endif
      CFG_B: begin
        code_nxt = c2_q ? D2_2 : D21_5;
        cfg_nxt  = cg.tx_config_reg;
      end
      CFG_C: begin
        code_nxt = cfg_q[7:0];
        even_nxt = 1'b1;
      end
      CFG_D: begin
        code_nxt = cfg_q[15:8];
        ind_nxt  = 1'b1;
        c2_nxt   = ~c2_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pcs_tx_code_group.sv
// Scoreboard bench: stimulus pushes expected octets, a monitor pops one per edge.
module tb_pcs_tx_code_group;
  import pcs_pkg::*;

  typedef struct {
    logic [7:0] code;
    logic       k;
    logic       even;
    logic       ind;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic power_on = 1'b0;
  logic mr_main_reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  pcs_tx_code_group_if bus ();

  pcs_tx_code_group dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .power_on     (power_on),
    .mr_main_reset(mr_main_reset),
    .cg           (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic compare(input string nm, input exp_t e);
    checks++;
    if (bus.tx_code_group !== e.code || bus.tx_is_k !== e.k ||
        bus.tx_even !== e.even || bus.tx_oset_indicate !== e.ind) begin
      failures++;
      $display("FAIL %s: got cg=%02h k=%0b even=%0b ind=%0b, expected cg=%02h k=%0b even=%0b ind=%0b",
               nm, bus.tx_code_group, bus.tx_is_k, bus.tx_even, bus.tx_oset_indicate,
               e.code, e.k, e.even, e.ind);
    end
  endtask

  // Monitor: outputs are registered, so each pushed entry is due just after the next edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare(e.name, e);
      end
    end
  end

  task automatic cyc(input ordered_set_t os, input logic [7:0] code, input logic k,
                     input logic even, input logic ind, input string nm);
    exp_t e;
    bus.tx_o_set = os;
    e.code = code; e.k = k; e.even = even; e.ind = ind; e.name = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic gmii(input logic en, input logic er, input logic [7:0] d);
    bus.TX_EN = en;
    bus.TX_ER = er;
    bus.TXD   = d;
  endtask

  initial begin
    exp_t z;
    z.code = 8'h00; z.k = 1'b0; z.even = 1'b0; z.ind = 1'b0; z.name = "";
    bus.tx_o_set = OS_I;
    bus.tx_config_reg = 16'h0000;
    bus.tx_disparity_pos = 1'b0;
    gmii(1'b0, 1'b0, 8'h00);

    #2;
    compare("reset_state", z);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle, alternating disparity; second set changes tx_o_set mid-set (ignored)
    cyc(OS_I, 8'hBC, 1, 1, 0, "idle1_a");
    bus.tx_disparity_pos = 1'b1;
    cyc(OS_I, 8'hC5, 0, 0, 1, "idle1_b");
    cyc(OS_I, 8'hBC, 1, 1, 0, "idle2_a");
    bus.tx_disparity_pos = 1'b0;
    cyc(OS_S, 8'h50, 0, 0, 1, "idle2_b_midset");

    // Config C1 then C2; config input changes during CFG_C must not leak
    bus.tx_config_reg = 16'h41A0;
    cyc(OS_C, 8'hBC, 1, 1, 0, "cfg1_a");
    cyc(OS_C, 8'hB5, 0, 0, 0, "cfg1_b");
    bus.tx_config_reg = 16'hFFFF;
    cyc(OS_C, 8'hA0, 0, 1, 0, "cfg1_c_hold");
    cyc(OS_C, 8'h41, 0, 0, 1, "cfg1_d_hold");
    bus.tx_config_reg = 16'h41A0;
    cyc(OS_C, 8'hBC, 1, 1, 0, "cfg2_a");
    cyc(OS_C, 8'h42, 0, 0, 0, "cfg2_b_c2");
    cyc(OS_C, 8'hA0, 0, 1, 0, "cfg2_c");
    cyc(OS_C, 8'h41, 0, 0, 1, "cfg2_d");
    cyc(OS_C, 8'hBC, 1, 1, 0, "cfg3_a");
    cyc(OS_C, 8'hB5, 0, 0, 0, "cfg3_b_c1");
    cyc(OS_C, 8'hA0, 0, 1, 0, "cfg3_c");
    cyc(OS_C, 8'h41, 0, 0, 1, "cfg3_d");

    // Packet
    cyc(OS_S, 8'hFB, 1, 1, 1, "pkt_s");
    gmii(1'b1, 1'b0, 8'h55);
    cyc(OS_D, 8'h55, 0, 0, 1, "pkt_d0");
    cyc(OS_D, 8'h55, 0, 1, 1, "pkt_d1");
    cyc(OS_D, 8'h55, 0, 0, 1, "pkt_d2");
    gmii(1'b0, 1'b0, 8'h00);
    cyc(OS_T, 8'hFD, 1, 1, 1, "pkt_t");
    cyc(OS_R, 8'hF7, 1, 0, 1, "pkt_r0");
    cyc(OS_R, 8'hF7, 1, 1, 1, "pkt_r1");

    // VOID substitution boundaries
    gmii(1'b1, 1'b1, 8'h55);
    cyc(OS_D, 8'hFE, 1, 0, 1, "void_d_en_er");
    gmii(1'b0, 1'b1, 8'h0F);
    cyc(OS_R, 8'hF7, 1, 1, 1, "r_er_0f_novoid");
    gmii(1'b1, 1'b0, 8'h00);
    cyc(OS_T, 8'hFE, 1, 0, 1, "void_t_en");
    gmii(1'b0, 1'b1, 8'h00);
    cyc(OS_R, 8'hFE, 1, 1, 1, "void_r_er");
    gmii(1'b0, 1'b0, 8'h00);
    cyc(OS_V, 8'hFE, 1, 0, 1, "os_v");

    // Restart during CFG_C, then clean /C/ starting at C1, then C2
    cyc(OS_C, 8'hBC, 1, 1, 0, "rst_cfg_a");
    cyc(OS_C, 8'hB5, 0, 0, 0, "rst_cfg_b");
    mr_main_reset = 1'b1;
    cyc(OS_C, 8'h00, 0, 0, 0, "mr_main_reset");
    mr_main_reset = 1'b0;
    cyc(OS_C, 8'hBC, 1, 1, 0, "post_rst_a");
    cyc(OS_C, 8'hB5, 0, 0, 0, "post_rst_b_c1");
    cyc(OS_C, 8'hA0, 0, 1, 0, "post_rst_c");
    cyc(OS_C, 8'h41, 0, 0, 1, "post_rst_d");
    cyc(OS_C, 8'hBC, 1, 1, 0, "post_rst2_a");
    cyc(OS_C, 8'h42, 0, 0, 0, "post_rst2_b_c2");
    cyc(OS_C, 8'hA0, 0, 1, 0, "post_rst2_c");
    cyc(OS_C, 8'h41, 0, 0, 1, "post_rst2_d");

    // power_on during IDLE_B
    cyc(OS_I, 8'hBC, 1, 1, 0, "pon_idle_a");
    power_on = 1'b1;
    cyc(OS_I, 8'h00, 0, 0, 0, "power_on");
    power_on = 1'b0;
    cyc(OS_S, 8'hFB, 1, 1, 1, "post_pon_s");

    // LPI
    bus.tx_disparity_pos = 1'b0;
    cyc(OS_LI, 8'hBC, 1, 1, 0, "li_a");
`ifdef PCS_TX_LPI_EN
    cyc(OS_LI, 8'h9A, 0, 0, 1, "li_b_neg");
`else
    cyc(OS_LI, 8'h50, 0, 0, 1, "li_b_neg");
`endif
    cyc(OS_LI, 8'hBC, 1, 1, 0, "li2_a");
    bus.tx_disparity_pos = 1'b1;
`ifdef PCS_TX_LPI_EN
    cyc(OS_LI, 8'hA6, 0, 0, 1, "li2_b_pos");
`else
    cyc(OS_LI, 8'hC5, 0, 0, 1, "li2_b_pos");
`endif

    // Asynchronous reset mid-/C/, then a clean /I/
    cyc(OS_C, 8'hBC, 1, 1, 0, "async_cfg_a");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    compare("async_reset", z);
    @(negedge clk);
    rst_n = 1'b1;
    bus.tx_disparity_pos = 1'b0;
    cyc(OS_I, 8'hBC, 1, 1, 0, "post_async_a");
    cyc(OS_I, 8'h50, 0, 0, 1, "post_async_b");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcs_tx_code_group.md
# pcs_tx_code_group

PCS transmit code-group generator (IEEE 802.3-2022 Clause 36, Figure 36-6). It consumes the ordered-set stream from the transmit ordered-set state machine and emits one 8-bit code group plus K flag per clock toward the 8B/10B encoder. It returns `tx_even` and `tx_oset_indicate` to the ordered-set stage. It performs VOID substitution, selects /I1/ or /I2/ from the current running disparity, and sequences /C1/ and /C2/ configuration sets.

## Interface
- No parameters. Code-group values are fixed constants in `pcs_pkg`.
- `clk  in  1` — code-group clock; one code group per cycle.
- `rst_n  in  1` — reset, asynchronous, active-low.
- `power_on  in  1` — synchronous restart to GEN_CG.
- `mr_main_reset  in  1` — synchronous restart to GEN_CG.
- `tx_o_set  in  ordered_set_t` — one of OS_C/I/S/T/R/V/D/LI.
- `TX_EN  in  1`, `TX_ER  in  1`, `TXD  in  8` — GMII inputs, used for /D/ data and VOID.
- `tx_config_reg  in  16` — auto-negotiation config word.
- `tx_disparity_pos  in  1` — encoder running disparity is positive.
- `tx_code_group  out  8` — octet to the encoder.
- `tx_is_k  out  1` — octet is a K code.
- `tx_even  out  1` — even/odd alignment.
- `tx_oset_indicate  out  1` — last code group of the current ordered set.

## Operation
- States:
  - GEN_CG: boundary; samples `tx_o_set`.
  - IDLE_B, LPI_B: second group of /I/ and /LI/.
  - CFG_B, CFG_C, CFG_D: groups 2–4 of /C/.
- Each register edge out of GEN_CG launches the first code group of the newly sampled set.
- Sampled in GEN_CG:
  - OS_I: K28.5 (0xBC,k), even=1 → IDLE_B. IDLE_B emits D5.6 (0xC5) if `tx_disparity_pos`, else D16.2 (0x50); even=0, indicate=1 → GEN_CG.
  - OS_C: K28.5, even=1 → CFG_B. CFG_B emits D21.5 (0xB5) for C1, D2.2 (0x42) for C2, even=0. CFG_C emits `cfg[7:0]`, even=1. CFG_D emits `cfg[15:8]`, even=0, indicate=1.
    - C1/C2 toggle flips after every completed /C/.
    - `tx_config_reg` is captured at the CFG_B launch edge and held for CFG_C/CFG_D.
  - OS_S: K27.7 (0xFB). OS_T: K29.7 (0xFD). OS_R: K23.7 (0xF7). OS_V: K30.7 (0xFE). OS_D: TXD, k=0.
    - All single-group sets: indicate=1, even=!even, stay in GEN_CG.
  - OS_LI: see Configuration.
- VOID substitution (single-group sets only); output becomes K30.7:
  - OS_D with TX_EN=1 and TX_ER=1.
  - OS_T or OS_R with TX_EN=0, TX_ER=1 and TXD≠0x0F.
  - OS_T or OS_R with TX_EN=1 (any TX_ER).
- Unknown `tx_o_set` encoding: treated as OS_I.
- C1/C2 toggle resets to C1. It also returns to C1 whenever a non-C set is sampled.

## Timing
- All outputs registered.
- Reset values: `tx_code_group`=0x00, `tx_is_k`=0, `tx_even`=0, `tx_oset_indicate`=0, state=GEN_CG, toggle=C1.
- `tx_oset_indicate` is high in exactly the cycle the last group of a set is on the outputs.
- The next `tx_o_set` is sampled on the edge following that indicate.
- `tx_o_set` changes mid-set are ignored; the set always completes.
- `tx_disparity_pos` is sampled combinationally on the IDLE_B/LPI_B launch edge.
- `power_on` or `mr_main_reset` high: the next edge forces GEN_CG and the reset output values (indicate=0). Sampling resumes on the following edge.
- Asynchronous reset mid-set abandons the set; the first post-reset set starts cleanly.

## Configuration
- Macro: `PCS_TX_LPI_EN`.
- Defined: OS_LI emits K28.5, even=1 → LPI_B.
  - LPI_B emits D6.5 (0xA6, /LI1/) if `tx_disparity_pos`, else D26.4 (0x9A, /LI2/).
  - LPI_B: even=0, indicate=1.
- Undefined: LPI_B does not exist and OS_LI is encoded exactly as OS_I.

## Test plan
- **Idle:** OS_I continuous, disparity_pos alternating 1/0 per set → 0xBC/0xC5, 0xBC/0x50 repeating. tx_even 1,0; indicate on every 2nd cycle.
- **Config:** OS_C continuous, cfg=0x41A0 → BC B5 A0 41 BC 42 A0 41; indicate on cycles 4 and 8.
- **Packet:** S, D(0x55 ×3), T, R, R with TX_ER=0 → FB 55 55 55 FD F7 F7 (k only on FB/FD/F7). indicate every cycle; tx_even alternating.
- **VOID:** OS_D with TX_EN=1, TX_ER=1 → 0xFE, k=1. OS_R with TX_EN=0, TX_ER=1, TXD=0x0F → 0xF7 (no void).
- **Restart:** mr_main_reset pulse during CFG_C → next cycle outputs 0x00/0/0/0. The next set starts with 0xBC and toggle=C1.
- **LPI:** `PCS_TX_LPI_EN` defined, OS_LI with disparity_pos=0 → BC 9A. Undefined → BC 50.
